// File: rtl/msx_bus_pkg.sv
// Shared types and timing constants for the MSX bus sequencer.
// TIMEOUT_CYC is only used when NWAIT_TIMEOUT_EN is defined.
package msx_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int TIMEOUT_CYC    = 256;
  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_STROBE_CYC = 3;
  localparam int DEF_HOLD_CYC   = 1;

  // Down-counter load for an N-cycle state; 0 behaves as 1, large values saturate.
  function automatic logic [7:0] cyc_load(input int n);
    if (n <= 1) return 8'd0;
    if (n >= 256) return 8'd255;
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/msx_rr_arbiter2.sv
// Two-way round-robin arbiter; combinational grant, pointer flop records the last winner.
// With both requests set the requester not granted last wins; pointer moves only on i_take.
module msx_rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_vld,
  output logic       o_idx
);

  logic r_last;
  logic w_idx;

  always_comb begin
    w_idx = i_req[1];
    if (i_req == 2'b11) w_idx = ~r_last;
  end

  assign o_vld = |i_req;
  assign o_idx = w_idx;

  // Reset value 1 makes requester 0 the favoured one.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_last <= 1'b1;
    else if (i_take && o_vld) r_last <= w_idx;
  end

endmodule

// File: rtl/msx_bus_sequencer.sv
// MSX bus cycle sequencer: IDLE -> SETUP -> STROBE -> HOLD, ack one cycle after HOLD ends.
// Define NWAIT_TIMEOUT_EN to abort a STROBE after 256 consecutive nwait-low cycles (err = 1).
module msx_bus_sequencer
  import msx_bus_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_we,
  input  logic [1:0]  i_io,
  input  logic [31:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [1:0]  o_ack,
  output logic        o_err,
  output logic [7:0]  o_rdata,
  output logic [15:0] o_address,
  output logic [7:0]  o_data_out,
  output logic        o_data_oe,
  input  logic [7:0]  i_data_in,
  output logic        o_rd_n,
  output logic        o_wr_n,
  output logic        o_iorq_n,
  output logic        o_merq_n,
  output logic        o_sltsl_n,
  input  logic        i_nwait,
  output logic        o_busy
);

  localparam logic [7:0] L_SETUP  = cyc_load(SETUP_CYC);
  localparam logic [7:0] L_STROBE = cyc_load(STROBE_CYC);
  localparam logic [7:0] L_HOLD   = cyc_load(HOLD_CYC);

  state_e      r_state;
  state_e      w_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        r_idx;
  logic        r_we;
  logic        r_io;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [1:0]  r_ack;
  logic        r_err;
  logic        w_arb_vld;
  logic        w_arb_idx;
  logic        w_take;
  logic        w_strobe_done;
  logic        w_tmo_hit;
  logic        w_tmo_flag;

  msx_rr_arbiter2 u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (i_req),
    .i_take  (r_state == ST_IDLE),
    .o_vld   (w_arb_vld),
    .o_idx   (w_arb_idx)
  );

`ifdef NWAIT_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_tmo;

  assign w_tmo_hit  = (r_state == ST_STROBE) && !i_nwait && (r_wait_cnt == 8'(TIMEOUT_CYC - 1));
  assign w_tmo_flag = r_tmo;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wait_cnt <= 8'd0;
      r_tmo      <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == ST_STROBE && !i_nwait) ? r_wait_cnt + 8'd1 : 8'd0;
      if (w_take) r_tmo <= 1'b0;
      else if (w_tmo_hit) r_tmo <= 1'b1;
    end
  end
`else
  assign w_tmo_hit  = 1'b0;
  assign w_tmo_flag = 1'b0;
`endif

  always_comb begin
    w_next        = r_state;
    w_cnt_nxt     = r_cnt;
    w_take        = 1'b0;
    w_strobe_done = 1'b0;
    o_rd_n        = 1'b1;
    o_wr_n        = 1'b1;
    o_iorq_n      = 1'b1;
    o_merq_n      = 1'b1;
    o_sltsl_n     = 1'b1;
    o_data_oe     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_vld) begin
          w_take    = 1'b1;
          w_next    = ST_SETUP;
          w_cnt_nxt = L_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 8'd0) begin
          w_next    = ST_STROBE;
          w_cnt_nxt = L_STROBE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_STROBE: begin
        // nwait only matters once the minimum strobe width has elapsed.
        if (w_tmo_hit || (r_cnt == 8'd0 && i_nwait)) begin
          w_next        = ST_HOLD;
          w_cnt_nxt     = L_HOLD;
          w_strobe_done = 1'b1;
        end else if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
        o_rd_n = r_we;
        o_wr_n = ~r_we;
      end
      ST_HOLD: begin
        if (r_cnt == 8'd0) w_next = ST_IDLE;
        else w_cnt_nxt = r_cnt - 8'd1;
      end
      default: w_next = ST_IDLE;
    endcase
    if (r_state != ST_IDLE) begin
      o_iorq_n  = ~r_io;
      o_merq_n  = r_io;
      o_sltsl_n = r_io;
      o_data_oe = r_we;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_idx   <= 1'b0;
      r_we    <= 1'b0;
      r_io    <= 1'b0;
      r_addr  <= 16'd0;
      r_wdata <= 8'd0;
      r_rdata <= 8'd0;
      r_ack   <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= 2'b00;
      r_err   <= 1'b0;
      if (w_take) begin
        r_idx   <= w_arb_idx;
        r_we    <= i_we[w_arb_idx];
        r_io    <= i_io[w_arb_idx];
        r_addr  <= w_arb_idx ? i_addr[31:16] : i_addr[15:0];
        r_wdata <= w_arb_idx ? i_wdata[15:8] : i_wdata[7:0];
      end
      if (w_strobe_done && !r_we && !w_tmo_hit) r_rdata <= i_data_in;
      if (r_state == ST_HOLD && r_cnt == 8'd0) begin
        r_ack <= r_idx ? 2'b10 : 2'b01;
        r_err <= w_tmo_flag;
      end
    end
  end

  assign o_ack      = r_ack;
  assign o_err      = r_err;
  assign o_rdata    = r_rdata;
  assign o_address  = r_addr;
  assign o_data_out = r_wdata;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_msx_bus_sequencer.sv
// Scoreboard bench for msx_bus_sequencer: stimulus pushes expected acks, a negedge monitor checks them.
module tb_msx_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we_v, io_v;
  logic [31:0] addr_v;
  logic [15:0] wdata_v;
  logic [7:0]  data_in;
  logic        nwait;
  logic [1:0]  o_ack;
  logic        o_err, o_data_oe, o_rd_n, o_wr_n, o_iorq_n, o_merq_n, o_sltsl_n, o_busy;
  logic [7:0]  o_rdata, o_data_out;
  logic [15:0] o_address;

  msx_bus_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we_v), .i_io(io_v),
    .i_addr(addr_v), .i_wdata(wdata_v), .o_ack(o_ack), .o_err(o_err),
    .o_rdata(o_rdata), .o_address(o_address), .o_data_out(o_data_out),
    .o_data_oe(o_data_oe), .i_data_in(data_in), .o_rd_n(o_rd_n), .o_wr_n(o_wr_n),
    .o_iorq_n(o_iorq_n), .o_merq_n(o_merq_n), .o_sltsl_n(o_sltsl_n),
    .i_nwait(nwait), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic        err;
    logic        we;
    logic [7:0]  rdata;
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic [95:0] lens;
    int          lat;
    int          issue_cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_rd = 8'd0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Bus-side expectations from default timing: SETUP 2, HOLD 1, given strobe width.
  task automatic issue(input int idx, input bit we, input bit io, input logic [15:0] a,
                       input logic [7:0] wd, input logic [7:0] din, input int strobe,
                       input bit err, input bit track);
    exp_t e;
    logic [15:0] s16, sel16;
    int sel;
    sel   = 2 + strobe + 1;
    s16   = 16'(strobe);
    sel16 = 16'(sel);
    if (!we && !err) last_rd = din;
    e.idx  = idx;
    e.err  = err;
    e.we   = we;
    e.addr = a;
    e.wdat = wd;
    e.rdata = last_rd;
    e.lens = {we ? 16'd0 : s16, we ? s16 : 16'd0, io ? 16'd0 : sel16,
              io ? 16'd0 : sel16, io ? sel16 : 16'd0, we ? sel16 : 16'd0};
    e.lat = track ? sel + 1 : -1;
    e.issue_cyc = cyc;
    q.push_back(e);
    req[idx]  = 1'b1;
    we_v[idx] = we;
    io_v[idx] = io;
    addr_v[idx*16 +: 16] = a;
    wdata_v[idx*8 +: 8]  = wd;
    data_in = din;
  endtask

  task automatic wait_ack(input int idx, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_ack[idx] && k < budget);
    if (!o_ack[idx]) timeout_fail($sformatf("ack_wait_req%0d", idx));
    req[idx] = 1'b0;
  endtask

  task automatic wait_strobe(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_rd_n && k < budget);
    if (o_rd_n) timeout_fail("rd_strobe_wait");
  endtask

  // Monitor: measures each bus cycle and checks it against the scoreboard on ack.
  logic [15:0] m_rd, m_wr, m_merq, m_sltsl, m_iorq, m_oe, m_addr;
  logic [7:0]  m_dout;

  task automatic mon_clear();
    m_rd = 0; m_wr = 0; m_merq = 0; m_sltsl = 0; m_iorq = 0; m_oe = 0;
    m_addr = 16'hxxxx; m_dout = 8'hxx;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_clear();
    end else begin
      if (!o_rd_n)    m_rd++;
      if (!o_wr_n)    begin m_wr++; m_dout = o_data_out; end
      if (!o_merq_n)  m_merq++;
      if (!o_sltsl_n) m_sltsl++;
      if (!o_iorq_n)  m_iorq++;
      if (o_data_oe)  m_oe++;
      if (!o_merq_n || !o_iorq_n) m_addr = o_address;
      if (o_ack != 2'b00) begin
        if (q.size() == 0) begin
          chk("spurious_ack", 96'(o_ack), 96'd0);
        end else begin
          mon_e = q.pop_front();
          chk("ack_bits", 96'(o_ack), mon_e.idx == 1 ? 96'd2 : 96'd1);
          chk("err", 96'(o_err), 96'(mon_e.err));
          chk("rdata", 96'(o_rdata), 96'(mon_e.rdata));
          chk("lens_rd_wr_merq_sltsl_iorq_oe", {m_rd, m_wr, m_merq, m_sltsl, m_iorq, m_oe}, mon_e.lens);
          chk("address", 96'(m_addr), 96'(mon_e.addr));
          if (mon_e.we) chk("data_out", 96'(m_dout), 96'(mon_e.wdat));
          if (mon_e.lat >= 0) chk("latency", 96'(cyc - mon_e.issue_cyc), 96'(mon_e.lat));
        end
        mon_clear();
      end
    end
  end

  localparam logic [44:0] RESET_VIEW = {2'b00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 5'b11111, 1'b0, 3'b000};

  function automatic logic [44:0] reset_view();
    return {o_ack, o_err, o_data_oe, o_address, o_data_out, o_rdata,
            o_rd_n, o_wr_n, o_iorq_n, o_merq_n, o_sltsl_n, o_busy, 3'b000};
  endfunction

  initial begin
    int k;
    int arb_start;
    rst = 1'b1; req = 2'b00; we_v = 2'b00; io_v = 2'b00;
    addr_v = 32'd0; wdata_v = 16'd0; data_in = 8'd0; nwait = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", 96'(reset_view()), 96'(RESET_VIEW));
    rst = 1'b0;
    @(negedge clk);

    // Memory read by requester 0, default timing.
    issue(0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'hA5, 3, 1'b0, 1'b1);
    wait_ack(0, 50);

    // Memory write whose req is dropped mid-cycle still completes.
    issue(0, 1'b1, 1'b0, 16'hC123, 8'h81, 8'h00, 3, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    req[0] = 1'b0;
    wait_ack(0, 50);

    // I/O write by requester 1.
    issue(1, 1'b1, 1'b1, 16'h0098, 8'h3C, 8'h00, 3, 1'b0, 1'b1);
    wait_ack(1, 50);

    // Both requesting: alternate 0,1,0,1 with one IDLE cycle between bus cycles.
    arb_start = cyc;
    issue(0, 1'b1, 1'b0, 16'h1234, 8'h11, 8'h00, 3, 1'b0, 1'b0);
    issue(1, 1'b0, 1'b0, 16'h8000, 8'h00, 8'h77, 3, 1'b0, 1'b0);
    issue(0, 1'b1, 1'b0, 16'h1234, 8'h11, 8'h00, 3, 1'b0, 1'b0);
    issue(1, 1'b0, 1'b0, 16'h8000, 8'h00, 8'h77, 3, 1'b0, 1'b0);
    k = 0;
    for (int n = 0; n < 4 && k < 200; ) begin
      @(negedge clk);
      k++;
      if (o_ack != 2'b00) n++;
      if (n == 4) begin
        req = 2'b00;
        chk("arb_span_cycles", 96'(cyc - arb_start), 96'd28);
      end
    end
    if (k >= 200) begin
      timeout_fail("arb_acks");
      req = 2'b00;
    end

    // nwait low for 10 cycles from the 2nd strobe cycle stretches rd_n to 12.
    issue(0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'hC7, 12, 1'b0, 1'b1);
    wait_strobe(20);
    @(negedge clk);
    nwait = 1'b0;
    repeat (10) @(negedge clk);
    nwait = 1'b1;
    wait_ack(0, 50);

`ifdef NWAIT_TIMEOUT_EN
    issue(0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'hEE, 256, 1'b1, 1'b1);
    wait_strobe(20);
    nwait = 1'b0;
    wait_ack(0, 400);
    nwait = 1'b1;
`endif

    // Reset in the 2nd strobe cycle of a requester-0 read.
    req[0] = 1'b1; we_v[0] = 1'b0; io_v[0] = 1'b0; addr_v[15:0] = 16'h5555; data_in = 8'h99;
    wait_strobe(20);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("strobes_on_reset", 96'({o_rd_n, o_wr_n, o_iorq_n, o_merq_n, o_sltsl_n, o_busy, o_data_oe}), 96'(7'b1111100));
    req = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("ack_in_reset", 96'(o_ack), 96'd0);
    end
    chk("reset_state_mid", 96'(reset_view()), 96'(RESET_VIEW));
    rst = 1'b0;
    last_rd = 8'h00;
    @(negedge clk);
    chk("no_ack_after_reset", 96'(o_ack), 96'd0);

    issue(0, 1'b1, 1'b0, 16'h2000, 8'h42, 8'h00, 3, 1'b0, 1'b1);
    issue(1, 1'b0, 1'b1, 16'h00A8, 8'h00, 8'h5A, 3, 1'b0, 1'b0);
    wait_ack(0, 50);
    wait_ack(1, 50);

    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("scoreboard_drained", 96'(q.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/msx_bus_sequencer.md
MSX_BUS_SEQUENCER -- requirements
Module: msx_bus_sequencer

Interface
REQ-001 Parameter SETUP_CYC, default 2: clk cycles that address and select are valid before the strobe.
REQ-002 Parameter STROBE_CYC, default 3: minimum clk cycles with rd_n or wr_n low.
REQ-003 Parameter HOLD_CYC, default 1: clk cycles after the strobe during which address, select and write data stay valid.
REQ-004 clk  in  1  single block clock; every flop is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  2  per-requester cycle request, bit n = requester n.
REQ-007 we  in  2  per-requester direction, 1 = write.
REQ-008 io  in  2  per-requester space, 1 = I/O (iorq), 0 = memory (merq + sltsl).
REQ-009 addr  in  32  per-requester address, [15:0] = requester 0, [31:16] = requester 1.
REQ-010 wdata  in  16  per-requester write data, [7:0] = requester 0, [15:8] = requester 1.
REQ-011 ack  out  2  one-cycle completion pulse to the granted requester.
REQ-012 err  out  1  valid with ack; 1 = cycle aborted on timeout.
REQ-013 rdata  out  8  captured read data, valid from ack until the next ack.
REQ-014 address  out  16  MSX address bus.
REQ-015 data_out, data_oe, data_in  out/out/in  8/1/8  MSX data bus drive value, drive enable and sampled value.
REQ-016 rd_n, wr_n, iorq_n, merq_n, sltsl_n  out  1 each  active-low MSX strobes and selects.
REQ-017 nwait  in  1  active-low MSX wait, already synchronised.
REQ-018 busy  out  1  high in every state other than IDLE.

Function
REQ-019 FSM states: IDLE, SETUP, STROBE, HOLD; one 8-bit down-counter times each state.
REQ-020 IDLE with any req bit set: latch the winner's we, io, addr and wdata; go to SETUP on the next edge.
REQ-021 Arbitration is round-robin; with both req bits set, the requester not granted last wins; the pointer flips only on a grant.
REQ-022 SETUP: address is driven; iorq_n = 0 for I/O, or merq_n = 0 and sltsl_n = 0 for memory; on writes data_oe = 1; lasts exactly SETUP_CYC cycles.
REQ-023 STROBE: rd_n or wr_n = 0; lasts at least STROBE_CYC cycles and is extended while nwait = 0 on the final counted cycle.
REQ-024 Reads: data_in is captured into rdata on the edge that leaves STROBE.
REQ-025 HOLD: rd_n and wr_n = 1; selects, address and data_oe are unchanged; lasts HOLD_CYC cycles, then the block returns to IDLE and pulses ack for the granted requester.
REQ-026 Cycle latency without wait: SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 clocks from the req sample to ack.
REQ-027 Deasserting req mid-cycle is ignored; the cycle completes and ack still pulses.
REQ-028 A request pending at ack is granted in the IDLE cycle that follows; IDLE always lasts at least one cycle between cycles.
REQ-029 Parameters of 0 are treated as 1.

Reset
REQ-030 While reset is high: state = IDLE; all active-low outputs = 1; ack = 0, err = 0, data_oe = 0; address, data_out and rdata = 0; the pointer favours requester 0.
REQ-031 Reset mid-cycle drops the strobes immediately (asynchronously) and no ack is generated.

Configuration
REQ-032 With NWAIT_TIMEOUT_EN defined: if nwait stays 0 for 256 consecutive STROBE cycles, the block goes to HOLD and the ack that follows has err = 1, with rdata unchanged.
REQ-033 Without NWAIT_TIMEOUT_EN: the block waits on nwait indefinitely and err is tied to 0.

Structure
REQ-034 A shared package msx_bus_pkg holds the state enum, the 256-cycle timeout constant and the default timing constants.
REQ-035 One sub-module, msx_rr_arbiter2 (2-way round-robin arbiter with a grant-pointer flop), is instantiated inside the block.

Verification
REQ-036 Requester 0 memory read at 0x4000 with defaults and data_in = 0xA5 -> sltsl_n and merq_n low for 6 cycles, rd_n low for 3 cycles, ack[0] on clock 7, rdata = 0xA5.
REQ-037 Requester 1 I/O write to port 0x98 with data 0x3C -> iorq_n low, wr_n low for 3 cycles, data_oe high from SETUP through HOLD, sltsl_n stays 1.
REQ-038 req = 2'b11 held for 4 cycles -> grant order 0, 1, 0, 1 and ack never high on both bits.
REQ-039 nwait held low for 10 cycles during STROBE -> rd_n low for 12 cycles; with NWAIT_TIMEOUT_EN and nwait stuck low -> err = 1 after 256 wait cycles.
REQ-040 Reset asserted in the 2nd STROBE cycle -> all strobes high within the same cycle, no ack, and a new request after reset is served by requester 0 first.
